// File: rtl/itof_arbiter.sv
// itof_arbiter: round-robin sharing of one pipelined int32->float32 unit among
// NREQ requesters, routing results back to per-requester holding registers.
module itof_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          itof_op,
    input  logic [31:0]          itof_result,
    output logic [NREQ-1:0]      resp_valid,
    output logic [NREQ*32-1:0]   resp_data,
    input  logic [NREQ-1:0]      resp_ready,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    state_e             state_q [NREQ];
    state_e             state_d [NREQ];
    logic [IW-1:0]      last_q, last_d;
    logic [31:0]        op_q, op_d;
    logic [NREQ*32-1:0] rdata_q, rdata_d;
    logic [LATENCY:0]   tv_q, tv_d;
    logic [IW-1:0]      ti_q [LATENCY+1];
    logic [IW-1:0]      ti_d [LATENCY+1];

    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant;
    logic               found;
    logic [IW-1:0]      gnt_idx;
    logic [IW:0]        cand;
    logic               cap;
    logic [IW-1:0]      cap_idx;

    assign cap     = tv_q[LATENCY];
    assign cap_idx = ti_q[LATENCY];

    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (state_q[i] == S_IDLE);
        end
    end

    // Search starts after last grant; wrap by subtraction so any NREQ works
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        grant   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k + 1);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && elig[cand[IW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = found && (gnt_idx == IW'(i));
        end
    end

    always_comb begin
        op_d    = op_q;
        rdata_d = rdata_q;
        last_d  = found ? gnt_idx : last_q;
        tv_d    = '0;
        tv_d[0] = found;
        ti_d[0] = gnt_idx;
        for (int k = 1; k <= LATENCY; k++) begin
            tv_d[k] = tv_q[k-1];
            ti_d[k] = ti_q[k-1];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                op_d = req_data[32*i +: 32];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (grant[i]) state_d[i] = S_FLIGHT;
                end
                S_FLIGHT: begin
                    if (cap && (cap_idx == IW'(i))) begin
                        state_d[i] = S_HOLD;
                        rdata_d[32*i +: 32] = itof_result;
                    end
                end
                S_HOLD: begin
                    if (resp_ready[i]) state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= S_IDLE;
            end
            for (int k = 0; k <= LATENCY; k++) begin
                ti_q[k] <= '0;
            end
            tv_q    <= '0;
            last_q  <= LAST_RST;
            op_q    <= '0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= state_d[i];
            end
            for (int k = 0; k <= LATENCY; k++) begin
                ti_q[k] <= ti_d[k];
            end
            tv_q    <= tv_d;
            last_q  <= last_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        busy       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = (state_q[i] == S_HOLD);
            busy          = busy | (state_q[i] != S_IDLE);
        end
    end

    assign req_ready = grant & {NREQ{reset}};
    assign itof_op   = op_q;
    assign resp_data = rdata_q;

endmodule
